// File: rtl/whirlpool_compress_ctrl.sv
// rtl/whirlpool_compress_ctrl.sv - Whirlpool compression sequencer sharing one external rho unit
//
// Computes H' = W[H](m) ^ H ^ m. Each round uses the external combinational
// round function twice: once on the key (round constant added) and once on the
// cipher state (round key added).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_block = m, in_chain = H
//   out_valid/out_ready   downstream handshake; out_hash = H'
//   rf_state_o, rf_key_o  operand and round key presented to rho
//   rf_use_const          rho adds round constant c[rf_round] instead of rf_key_o
//   rf_round              current round index (1..ROUNDS while running)
//   rf_result_i           combinational rho result
//   busy                  controller is not idle
module whirlpool_compress_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [0:511]   in_block,
   input  logic [0:511]   in_chain,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [0:511]   out_hash,
   output logic [0:511]   rf_state_o,
   output logic [0:511]   rf_key_o,
   output logic           rf_use_const,
   output logic [3:0]     rf_round,
   input  logic [0:511]   rf_result_i,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEY   = 2'd1,
      STATE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   state_t       state_q;
   state_t       state_d;
   logic [0:511] key_q;
   logic [0:511] st_q;
   logic [0:511] msg_q;
   logic [0:511] chain_q;
   logic [3:0]   round_q;
   logic [0:511] hash_q;
   logic         valid_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = KEY;
         KEY:     state_d = STATE;
         STATE:   state_d = (round_q == LAST_ROUND) ? DONE : KEY;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: the key register feeds rho as both operand and (ignored) key
   // during KEY; otherwise the cipher state is the operand and K the key.
   always_comb begin
      in_ready     = (state_q == IDLE);
      busy         = (state_q != IDLE);
      rf_use_const = (state_q == KEY);
      rf_state_o   = (state_q == KEY) ? key_q : st_q;
      rf_key_o     = key_q;
      rf_round     = round_q;
      out_valid    = valid_q;
      out_hash     = hash_q;
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         st_q    <= '0;
         msg_q   <= '0;
         chain_q <= '0;
         round_q <= '0;
         hash_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  key_q   <= in_chain;
                  st_q    <= in_block ^ in_chain;
                  msg_q   <= in_block;
                  chain_q <= in_chain;
                  round_q <= 4'd1;
               end
            end
            KEY: begin
               key_q <= rf_result_i;
            end
            STATE: begin
               st_q <= rf_result_i;
               if (round_q == LAST_ROUND) begin
                  // Miyaguchi-Preneel feed-forward of chaining value and message
                  hash_q  <= rf_result_i ^ chain_q ^ msg_q;
                  valid_q <= 1'b1;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
